// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM: state encoding,
// opcode constants, ALU operation codes and datapath mux select encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        StStart   = 4'd0,
        StFetch   = 4'd1,
        StDecode  = 4'd2,
        StMemAddr = 4'd3,
        StMemRd   = 4'd4,
        StMemWb   = 4'd5,
        StMemWr   = 4'd6,
        StExec    = 4'd7,
        StRWb     = 4'd8,
        StBranch  = 4'd9,
        StJump    = 4'd10,
        StAddiEx  = 4'd11,
        StAddiWb  = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    // State following DECODE; unsupported opcodes fall back to FETCH (nop).
    function automatic state_e decode_next(input logic [5:0] op);
        state_e nxt;
        case (op)
            OP_RTYPE:     nxt = StExec;
            OP_LW, OP_SW: nxt = StMemAddr;
            OP_BEQ:       nxt = StBranch;
            OP_J:         nxt = StJump;
            OP_ADDI:      nxt = StAddiEx;
            default:      nxt = StFetch;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_ctrl_perf.sv
// Performance counters for the main control FSM: free-running cycle count and
// completed-instruction count. Only instantiated when MC_CTRL_PERF_EN is defined.
module mc_ctrl_perf (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        fetch_entry_i,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instr_cnt_o
);

    logic [31:0] cycle_cnt_q, instr_cnt_q;

    // Both counters wrap naturally modulo 2^32.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (fetch_entry_i) begin
                instr_cnt_q <= instr_cnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt_o = cycle_cnt_q;
    assign instr_cnt_o = instr_cnt_q;

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM for the multicycle MIPS datapath. Sequences fetch, decode,
// execute, memory and writeback, stalling on mem_ready in the memory states.
// Optional performance counters are enabled by defining MC_CTRL_PERF_EN.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic [1:0]  pc_source,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        ALUOP1,
    output logic        ALUOP0,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        illegal_op
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       is_sw_q, is_sw_d;
    logic [1:0] aluop;

    // Branch qualification by zero happens in the datapath via pc_write_cond.
    logic unused_zero;
    assign unused_zero = zero;

    // State, sticky illegal flag and latched lw/sw selection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StStart;
            illegal_q <= 1'b0;
            is_sw_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            is_sw_q   <= is_sw_d;
        end
    end

    // Next-state logic; opcode is only looked at in DECODE, so lw/sw is latched there.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        is_sw_d   = is_sw_q;
        unique case (state_q)
            StStart:   state_d = StFetch;
            StFetch:   if (mem_ready) state_d = StDecode;
            StDecode: begin
                state_d = decode_next(opcode);
                is_sw_d = (opcode == OP_SW);
                if (decode_next(opcode) == StFetch) illegal_d = 1'b1;
            end
            StMemAddr: state_d = is_sw_q ? StMemWr : StMemRd;
            StMemRd:   if (mem_ready) state_d = StMemWb;
            StMemWb:   state_d = StFetch;
            StMemWr:   if (mem_ready) state_d = StFetch;
            StExec:    state_d = StRWb;
            StRWb:     state_d = StFetch;
            StBranch:  state_d = StFetch;
            StJump:    state_d = StFetch;
            StAddiEx:  state_d = StAddiWb;
            StAddiWb:  state_d = StFetch;
            default:   state_d = StStart;
        endcase
    end

    // Output decode from the state register; ir_write/pc_write in FETCH gate on mem_ready.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PC_SRC_ALU;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_REG;
        aluop         = ALUOP_ADD;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StDecode: begin
                alu_src_b = ALUB_IMM_SH;
            end
            StMemAddr, StAddiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            StExec: begin
                alu_src_a = 1'b1;
                aluop     = ALUOP_FUNCT;
            end
            StRWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            StBranch: begin
                alu_src_a     = 1'b1;
                aluop         = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
            end
            StJump: begin
                pc_write  = 1'b1;
                pc_source = PC_SRC_JUMP;
            end
            StAddiWb: begin
                reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign ALUOP1     = aluop[1];
    assign ALUOP0     = aluop[0];
    assign illegal_op = illegal_q;

`ifdef MC_CTRL_PERF_EN
    // An instruction completes on entry to FETCH from anything but START.
    logic fetch_entry;
    assign fetch_entry = (state_d == StFetch) && (state_q != StFetch) && (state_q != StStart);

    mc_ctrl_perf u_perf (
        .clk_i         (clk),
        .reset_i       (reset),
        .fetch_entry_i (fetch_entry),
        .cycle_cnt_o   (cycle_cnt),
        .instr_cnt_o   (instr_cnt)
    );
`else
    // Counters absent in this build.
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-cycle vector table with a scoreboard
// queue, followed by hand-written reset-mid-wait and counter sequences.
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0]  pc_source, alu_src_b;
    logic        alu_src_a, ALUOP1, ALUOP0, reg_dst, mem_to_reg, reg_write, illegal_op;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    mc_ctrl_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .ALUOP1        (ALUOP1),
        .ALUOP0        (ALUOP0),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .illegal_op    (illegal_op)
`ifdef MC_CTRL_PERF_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .instr_cnt     (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        logic [16:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [16:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Field order: mem_read mem_write iord ir_write pc_write pc_write_cond
    // pc_source[1:0] alu_src_a alu_src_b[1:0] aluop[1:0] reg_dst mem_to_reg
    // reg_write illegal_op.
    function automatic logic [16:0] mk(input logic mr, input logic mw, input logic io,
                                       input logic irw, input logic pcw, input logic pcwc,
                                       input logic [1:0] pcs, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] aop,
                                       input logic rd, input logic m2r, input logic rw);
        return {mr, mw, io, irw, pcw, pcwc, pcs, asa, asb, aop, rd, m2r, rw, 1'b0};
    endfunction

    logic [16:0] O_START, O_FR, O_FW, O_DEC, O_MADDR, O_MRD, O_MWB, O_MWR;
    logic [16:0] O_EXEC, O_RWB, O_BR, O_JMP, O_AEX, O_AWB;

    function automatic logic [16:0] actual();
        return {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_source,
                alu_src_a, alu_src_b, ALUOP1, ALUOP0, reg_dst, mem_to_reg, reg_write,
                illegal_op};
    endfunction

    task automatic add(input logic rst, input logic [5:0] op, input logic rdy,
                       input logic [16:0] exp);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name);
        logic [16:0] e, a;
        a = actual();
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %b", name, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", name, a, e);
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge and compare shortly after.
    task automatic apply(input logic rst, input logic [5:0] op, input logic rdy,
                         input logic [16:0] exp, input string name);
        @(negedge clk);
        reset     = rst;
        opcode    = op;
        mem_ready = rdy;
        zero      = 1'($urandom_range(0, 1));
        exp_q.push_back(exp);
        #1;
        check(name);
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    localparam logic [5:0] G = 6'h3f;  // opcode value that must be ignored

    initial begin
        O_START = '0;
        O_FW    = mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0);
        O_FR    = mk(1, 0, 0, 1, 1, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0);
        O_DEC   = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0, 0);
        O_MADDR = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0);
        O_MRD   = mk(1, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
        O_MWB   = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 1);
        O_MWR   = mk(0, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
        O_EXEC  = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 0, 0, 0);
        O_RWB   = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 1);
        O_BR    = mk(0, 0, 0, 0, 0, 1, 2'b01, 1, 2'b00, 2'b01, 0, 0, 0);
        O_JMP   = mk(0, 0, 0, 0, 1, 0, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0);
        O_AEX   = mk(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0);
        O_AWB   = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 1);

        // Release from reset, then R-type (FETCH again on cycle 5).
        add(0, G, 1, O_START);
        add(0, G, 1, O_FR);
        add(0, 6'h00, 0, O_DEC);
        add(0, G, 0, O_EXEC);
        add(0, G, 1, O_RWB);
        // lw with three wait cycles in MEM_RD.
        add(0, G, 1, O_FR);
        add(0, 6'h23, 1, O_DEC);
        add(0, G, 1, O_MADDR);
        add(0, G, 0, O_MRD);
        add(0, G, 0, O_MRD);
        add(0, G, 0, O_MRD);
        add(0, G, 1, O_MRD);
        add(0, G, 0, O_MWB);
        // sw with a FETCH stall and one MEM_WR wait; opcode garbled after DECODE.
        add(0, G, 0, O_FW);
        add(0, G, 1, O_FR);
        add(0, 6'h2b, 1, O_DEC);
        add(0, G, 1, O_MADDR);
        add(0, G, 0, O_MWR);
        add(0, G, 1, O_MWR);
        // beq, j, addi.
        add(0, G, 1, O_FR);
        add(0, 6'h04, 1, O_DEC);
        add(0, G, 1, O_BR);
        add(0, G, 1, O_FR);
        add(0, 6'h02, 1, O_DEC);
        add(0, G, 1, O_JMP);
        add(0, G, 1, O_FR);
        add(0, 6'h08, 1, O_DEC);
        add(0, G, 1, O_AEX);
        add(0, G, 1, O_AWB);
        // Illegal opcode: flag rises after DECODE and stays through 3 instructions.
        add(0, G, 1, O_FR);
        add(0, 6'h3f, 1, O_DEC);
        add(0, G, 1, O_FR | 17'd1);
        add(0, 6'h00, 1, O_DEC | 17'd1);
        add(0, G, 1, O_EXEC | 17'd1);
        add(0, G, 1, O_RWB | 17'd1);
        add(0, G, 1, O_FR | 17'd1);
        add(0, 6'h02, 1, O_DEC | 17'd1);
        add(0, G, 1, O_JMP | 17'd1);
        add(0, G, 1, O_FR | 17'd1);
        add(0, 6'h04, 1, O_DEC | 17'd1);
        add(0, G, 1, O_BR | 17'd1);
        add(0, G, 1, O_FR | 17'd1);

        reset = 1'b1; opcode = 6'h00; mem_ready = 1'b1; zero = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.push_back(O_START);
        #1;
        check("reset_state");

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].op, vecs[i].rdy, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // sw stalled in MEM_WR, then reset asserted mid-cycle.
        apply(0, 6'h2b, 1, O_DEC | 17'd1, "sw_dec");
        apply(0, G, 1, O_MADDR | 17'd1, "sw_addr");
        apply(0, G, 0, O_MWR | 17'd1, "sw_wait");
        #2;
        reset = 1'b1;
        exp_q.push_back(O_START);
        #1;
        check("async_reset");
        apply(1, G, 1, O_START, "reset_hold");
        apply(0, G, 1, O_START, "start_after_reset");
        apply(0, G, 1, O_FR, "fetch_after_reset");

        // Two R-type instructions, then counters.
        apply(0, 6'h00, 1, O_DEC, "r1_dec");
        apply(0, G, 1, O_EXEC, "r1_exec");
        apply(0, G, 1, O_RWB, "r1_wb");
        apply(0, G, 1, O_FR, "r2_fetch");
        apply(0, 6'h00, 1, O_DEC, "r2_dec");
        apply(0, G, 1, O_EXEC, "r2_exec");
        apply(0, G, 1, O_RWB, "r2_wb");
        apply(0, G, 0, O_FW, "r3_fetch_wait");
`ifdef MC_CTRL_PERF_EN
        check_val("instr_cnt", instr_cnt, 32'd2);
        check_val("cycle_cnt", cycle_cnt, 32'd9);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

- Main control state machine for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the register/memory/PC enables and mux selects, plus the two-bit ALU operation code consumed by the ALU control unit.
- Sits between the instruction register opcode field and the datapath, and stalls on a memory ready handshake.

## Interface
Parameters:
- none (state encoding and opcodes are in the shared package).

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- opcode  in  6  IR[31:26]; sampled in DECODE.
- zero  in  1  ALU zero flag; used in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero.
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- ALUOP1, ALUOP0  out  1 each  ALU operation: 00 = add, 01 = subtract, 10 = decode the funct field.
- reg_dst  out  1  register destination: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback data: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- illegal_op  out  1  sticky flag; set when an unsupported opcode is decoded.

## Operation
States: START, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, R_WB, BRANCH, JUMP, ADDI_EX, ADDI_WB.

Reset:
- State goes to START. All outputs are 0; illegal_op is 0.
- START drives no outputs and moves to FETCH unconditionally.

FETCH:
- Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, ALUOP=00, pc_source=00.
- ir_write and pc_write are 1 only in the cycle where mem_ready=1; that cycle also moves to DECODE.
- Otherwise the FSM holds in FETCH.

DECODE:
- Drives alu_src_a=0, alu_src_b=11, ALUOP=00 (branch target into ALUOut).
- Next state by opcode:
  - 000000 → EXEC
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDI_EX
  - any other opcode: set illegal_op and go to FETCH (the instruction executes as a nop).

MEM_ADDR:
- Drives alu_src_a=1, alu_src_b=10, ALUOP=00.
- Goes to MEM_RD for lw, MEM_WR for sw.

MEM_RD:
- Drives mem_read=1, iord=1.
- Holds until mem_ready, then goes to MEM_WB.

MEM_WB:
- Drives reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.

MEM_WR:
- Drives mem_write=1, iord=1.
- Holds until mem_ready, then goes to FETCH.

EXEC:
- Drives alu_src_a=1, alu_src_b=00, ALUOP=10. Next state R_WB.

R_WB:
- Drives reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.

BRANCH:
- Drives alu_src_a=1, alu_src_b=00, ALUOP=01, pc_write_cond=1, pc_source=01. Next state FETCH.

JUMP:
- Drives pc_write=1, pc_source=10. Next state FETCH.

ADDI_EX:
- Drives alu_src_a=1, alu_src_b=10, ALUOP=00. Next state ADDI_WB.

ADDI_WB:
- Drives reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.

Output defaults and flag:
- Any output not listed for a state is 0.
- illegal_op clears only on reset.

## Timing
- Outputs decode combinationally from the state register; the only Mealy terms are the FETCH ir_write/pc_write gating on mem_ready.
- Latency with mem_ready held at 1, FETCH to the next FETCH:
  - R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4.
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- While waiting, mem_read/mem_write stay asserted and iord stays stable.
- mem_ready outside the memory states is ignored.
- opcode is sampled only in DECODE; changes in any other state have no effect.
- Reset asserted in any state, including mid-wait: outputs go to 0 immediately (asynchronous). The pending access is abandoned; no register write or PC update occurs.

## Configuration
- MC_CTRL_PERF_EN defined: adds two 32-bit output ports.
  - cycle_cnt increments every cycle after reset.
  - instr_cnt increments on each DECODE→FETCH path completion, i.e. on entry to FETCH from any non-START state.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

## Structure
- Shared package mc_ctrl_pkg holds:
  - the state enum (4-bit encoding);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - ALUOP codes ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT;
  - the pc_source and alu_src_b select encodings.
- One sub-module, mc_ctrl_perf, holds the two counters. It is instantiated only under MC_CTRL_PERF_EN.

## Test plan
- Reset, then release with mem_ready=1 → START for 1 cycle with all outputs 0; FETCH next with mem_read=1, ir_write=1, pc_write=1, alu_src_b=01.
- opcode=000000, mem_ready=1 → states FETCH, DECODE, EXEC, R_WB; ALUOP=10 in EXEC; reg_write=1 and reg_dst=1 in R_WB; back in FETCH on cycle 5.
- opcode=100011 with mem_ready low for 3 cycles in MEM_RD → mem_read and iord held at 1 for 4 cycles; MEM_WB asserts reg_write=1 and mem_to_reg=1.
- opcode=000100 → BRANCH drives ALUOP=01, pc_write_cond=1, pc_source=01; opcode=000010 → JUMP drives pc_write=1, pc_source=10.
- opcode=111111 → illegal_op rises after DECODE and stays 1 through 3 further instructions; reset clears it to 0.
- Reset asserted mid MEM_WR wait → mem_write drops to 0 asynchronously; next state START. With MC_CTRL_PERF_EN: after 2 R-type instructions, instr_cnt=2.
